// File: rtl/cursor_input.sv
// cursor_input: debounced push-button front end producing an 8x8
// board cursor and placement/reject strobes for the game controller.
module cursor_input #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 10000000
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_enable,
  input  logic                 i_key_up,
  input  logic                 i_key_down,
  input  logic                 i_key_left,
  input  logic                 i_key_right,
  input  logic                 i_key_place,
  input  logic [0:7][0:7][1:0] i_board,
  output logic [2:0]           o_row,
  output logic [2:0]           o_col,
  output logic                 o_player_done,
  output logic                 o_reject
);

  localparam int NK   = 5;
  localparam int K_UP = 0;
  localparam int K_DN = 1;
  localparam int K_LF = 2;
  localparam int K_RT = 3;
  localparam int K_PL = 4;

  localparam int DBW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ?
                        REPEAT_DELAY : REPEAT_RATE;
  localparam int RPW  = $clog2(RMAX + 1);

  localparam logic [DBW-1:0] DB_LIM = DBW'(DEBOUNCE_CYCLES);
  localparam logic [RPW-1:0] RD_LIM = RPW'(REPEAT_DELAY - 1);
  localparam logic [RPW-1:0] RR_LIM = RPW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_LOCK
  } state_t;

  logic [NK-1:0]  w_raw;
  logic [NK-1:0]  r_sync1;
  logic [NK-1:0]  r_sync2;
  logic [NK-1:0]  w_deb;
  logic [NK-1:0]  r_deb_q;
  logic [NK-1:0]  w_press;

  logic           w_any_held;
  logic           w_dir_press;
  logic [3:0]     w_sel;
  logic [RPW-1:0] r_rep_cnt;
  logic           r_rep_run;
  logic [RPW-1:0] w_rep_lim;
  logic           w_step;
  logic [3:0]     w_ev;
  logic           w_place_ev;
  logic           w_cell_empty;

  state_t         r_state;
  state_t         w_state_nxt;
  logic           w_done_nxt;
  logic           w_rej_nxt;
  logic           w_move;

  logic [2:0]     r_row;
  logic [2:0]     r_col;
  logic [2:0]     w_row_nxt;
  logic [2:0]     w_col_nxt;
  logic           r_done;
  logic           r_rej;

  assign w_raw = {i_key_place, i_key_right, i_key_left,
                  i_key_down, i_key_up};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb_q <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_deb_q <= w_deb;
    end
  end

  for (genvar k = 0; k < NK; k++) begin : g_deb
    logic [DBW-1:0] r_cnt;
    logic           r_lvl;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_cnt <= '0;
        r_lvl <= 1'b0;
      end else if (r_sync2[k] == r_lvl) begin
        r_cnt <= '0;
      end else if (r_cnt == DB_LIM) begin
        r_lvl <= r_sync2[k];
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    assign w_deb[k] = r_lvl;
  end

  assign w_press     = w_deb & ~r_deb_q;
  assign w_any_held  = |w_deb[K_RT:K_UP];
  assign w_dir_press = |w_press[K_RT:K_UP];

  // Repeat follows the highest-priority held direction only.
  always_comb begin
    w_sel = '0;
    case (1'b1)
      w_deb[K_UP]: w_sel[K_UP] = 1'b1;
      w_deb[K_DN]: w_sel[K_DN] = 1'b1;
      w_deb[K_LF]: w_sel[K_LF] = 1'b1;
      w_deb[K_RT]: w_sel[K_RT] = 1'b1;
      default:     w_sel = '0;
    endcase
  end

  assign w_rep_lim = r_rep_run ? RR_LIM : RD_LIM;
  assign w_step    = w_any_held && !w_dir_press &&
                     (r_rep_cnt == w_rep_lim);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rep_cnt <= '0;
      r_rep_run <= 1'b0;
    end else if (w_dir_press || !w_any_held) begin
      r_rep_cnt <= '0;
      r_rep_run <= 1'b0;
    end else if (w_step) begin
      r_rep_cnt <= '0;
      r_rep_run <= 1'b1;
    end else begin
      r_rep_cnt <= r_rep_cnt + 1'b1;
    end
  end

  assign w_ev         = w_press[K_RT:K_UP] | (w_step ? w_sel : 4'b0);
  assign w_place_ev   = w_press[K_PL];
  assign w_cell_empty = (i_board[r_row][r_col] == 2'd2);

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_rej_nxt   = 1'b0;
    w_move      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_enable && !w_deb[K_PL])
          w_state_nxt = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (w_place_ev) begin
          if (w_cell_empty) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_LOCK;
          end else begin
            w_rej_nxt = 1'b1;
          end
        end else begin
          w_move = 1'b1;
          if (!i_enable)
            w_state_nxt = S_IDLE;
        end
      end
      S_LOCK: begin
        if (!i_enable)
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Opposing events in the same cycle cancel on that axis.
  always_comb begin
    w_row_nxt = r_row;
    w_col_nxt = r_col;
    if (w_move) begin
      if (w_ev[K_UP] && !w_ev[K_DN])
        w_row_nxt = r_row - 3'd1;
      else if (w_ev[K_DN] && !w_ev[K_UP])
        w_row_nxt = r_row + 3'd1;
      if (w_ev[K_LF] && !w_ev[K_RT])
        w_col_nxt = r_col - 3'd1;
      else if (w_ev[K_RT] && !w_ev[K_LF])
        w_col_nxt = r_col + 3'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_row   <= 3'd2;
      r_col   <= 3'd3;
      r_done  <= 1'b0;
      r_rej   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
      r_done  <= w_done_nxt;
      r_rej   <= w_rej_nxt;
    end
  end

  assign o_row         = r_row;
  assign o_col         = r_col;
  assign o_player_done = r_done;
  assign o_reject      = r_rej;

endmodule

// File: tb/tb_cursor_input.sv
// tb_cursor_input: directed checks of cursor movement, repeat,
// placement, reject and reset behaviour of cursor_input.
module tb_cursor_input;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic en;
  logic up, dn, lf, rt, pl;
  logic [0:7][0:7][1:0] board;
  logic [2:0] row, col;
  logic done, rej;

  int errors = 0;
  int checks = 0;
  int n_done = 0;
  int n_rej  = 0;

  cursor_input #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(20),
    .REPEAT_RATE(8)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_enable     (en),
    .i_key_up     (up),
    .i_key_down   (dn),
    .i_key_left   (lf),
    .i_key_right  (rt),
    .i_key_place  (pl),
    .i_board      (board),
    .o_row        (row),
    .o_col        (col),
    .o_player_done(done),
    .o_reject     (rej)
  );

  always @(negedge clk) begin
    if (done === 1'b1) n_done++;
    if (rej === 1'b1) n_rej++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_key(input int k, input logic v);
    case (k)
      0: up = v;
      1: dn = v;
      2: lf = v;
      3: rt = v;
      default: pl = v;
    endcase
  endtask

  task automatic press_key(input int k);
    set_key(k, 1'b1);
    tick(10);
    set_key(k, 1'b0);
    tick(10);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    en = 1'b0;
    up = 0; dn = 0; lf = 0; rt = 0; pl = 0;
    board = {64{2'd2}};
    tick(3);
    checks++;
    if ({row, col, done, rej} !== {3'd2, 3'd3, 2'b00}) begin
      errors++;
      $display("FAIL reset_hold: got r%0d c%0d d%b j%b want r2 c3 d0 j0",
               row, col, done, rej);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      checks++;
      if ({row, col, done, rej} !== {3'd2, 3'd3, 2'b00}) begin
        errors++;
        $display("FAIL reset_idle[%0d]: got r%0d c%0d d%b j%b want r2 c3 d0 j0",
                 i, row, col, done, rej);
      end
    end
  endtask

  task automatic test_right_steps;
    logic [2:0] e0, e1;
    en = 1'b1;
    tick(3);
    for (int i = 0; i < 3; i++) begin
      e0 = 3'(3 + i);
      e1 = 3'(4 + i);
      rt = 1'b1;
      tick(7);
      checks++;
      if (col !== e0) begin
        errors++;
        $display("FAIL right_early[%0d]: col=%0d want %0d", i, col, e0);
      end
      tick(1);
      checks++;
      if (col !== e1) begin
        errors++;
        $display("FAIL right_edge7[%0d]: col=%0d want %0d", i, col, e1);
      end
      tick(2);
      rt = 1'b0;
      tick(10);
    end
  endtask

  task automatic test_wrap;
    press_key(0);
    press_key(0);
    checks++;
    if (row !== 3'd0) begin
      errors++;
      $display("FAIL up_to_0: row=%0d want 0", row);
    end
    press_key(0);
    checks++;
    if (row !== 3'd7) begin
      errors++;
      $display("FAIL up_wrap: row=%0d want 7", row);
    end
    press_key(3);
    checks++;
    if (col !== 3'd7) begin
      errors++;
      $display("FAIL right_to_7: col=%0d want 7", col);
    end
    press_key(3);
    checks++;
    if (col !== 3'd0) begin
      errors++;
      $display("FAIL right_wrap: col=%0d want 0", col);
    end
    up = 1'b1;
    dn = 1'b1;
    tick(10);
    up = 1'b0;
    dn = 1'b0;
    tick(10);
    checks++;
    if ({row, col} !== {3'd7, 3'd0}) begin
      errors++;
      $display("FAIL up_down_cancel: r%0d c%0d want r7 c0", row, col);
    end
  endtask

  task automatic test_glitch_repeat;
    int st[6] = '{7, 27, 35, 43, 51, 59};
    int n;
    logic [2:0] exp_row;
    lf = 1'b1;
    tick(3);
    lf = 1'b0;
    tick(15);
    checks++;
    if ({row, col} !== {3'd7, 3'd0}) begin
      errors++;
      $display("FAIL left_glitch: r%0d c%0d want r7 c0", row, col);
    end
    dn = 1'b1;
    for (int c = 0; c < 75; c++) begin
      tick(1);
      n = 0;
      for (int j = 0; j < 6; j++)
        if (st[j] <= c) n++;
      exp_row = 3'(7 + n);
      checks++;
      if (row !== exp_row) begin
        errors++;
        $display("FAIL repeat[c%0d]: row=%0d want %0d", c, row, exp_row);
      end
      if (c == 59) dn = 1'b0;
    end
    tick(5);
  endtask

  task automatic test_place;
    int nd;
    press_key(0);
    press_key(0);
    press_key(0);
    press_key(3);
    press_key(3);
    press_key(3);
    checks++;
    if ({row, col} !== {3'd2, 3'd3}) begin
      errors++;
      $display("FAIL place_setup: r%0d c%0d want r2 c3", row, col);
    end
    board = {64{2'd0}};
    board[2][3] = 2'd2;
    nd = n_done;
    pl = 1'b1;
    tick(7);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL place_early: done=%b want 0", done);
    end
    tick(1);
    checks++;
    if ({done, rej, row, col} !== {2'b10, 3'd2, 3'd3}) begin
      errors++;
      $display("FAIL place_strobe: d%b j%b r%0d c%0d want d1 j0 r2 c3",
               done, rej, row, col);
    end
    tick(1);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL place_one_cycle: done=%b want 0", done);
    end
    tick(5);
    en = 1'b0;
    tick(5);
    en = 1'b1;
    tick(5);
    press_key(3);
    checks++;
    if ({row, col} !== {3'd2, 3'd3}) begin
      errors++;
      $display("FAIL held_place_frozen: r%0d c%0d want r2 c3", row, col);
    end
    checks++;
    if (n_done !== nd + 1) begin
      errors++;
      $display("FAIL held_place_no_repeat: strobes=%0d want %0d",
               n_done - nd, 1);
    end
    pl = 1'b0;
    tick(12);
    checks++;
    if (n_done !== nd + 1) begin
      errors++;
      $display("FAIL release_no_strobe: strobes=%0d want %0d",
               n_done - nd, 1);
    end
    press_key(3);
    checks++;
    if (col !== 3'd4) begin
      errors++;
      $display("FAIL reactive_right: col=%0d want 4", col);
    end
    press_key(2);
    checks++;
    if (col !== 3'd3) begin
      errors++;
      $display("FAIL reactive_left: col=%0d want 3", col);
    end
  endtask

  task automatic test_reject_reset;
    int nd, nr;
    board[2][3] = 2'd1;
    nd = n_done;
    nr = n_rej;
    pl = 1'b1;
    tick(8);
    checks++;
    if ({rej, done} !== 2'b10) begin
      errors++;
      $display("FAIL reject_strobe: j%b d%b want j1 d0", rej, done);
    end
    tick(1);
    checks++;
    if (rej !== 1'b0) begin
      errors++;
      $display("FAIL reject_one_cycle: rej=%b want 0", rej);
    end
    tick(1);
    pl = 1'b0;
    tick(10);
    checks++;
    if (n_rej !== nr + 1 || n_done !== nd) begin
      errors++;
      $display("FAIL reject_counts: rej=%0d done=%0d want 1 0",
               n_rej - nr, n_done - nd);
    end
    press_key(3);
    checks++;
    if (col !== 3'd4) begin
      errors++;
      $display("FAIL reject_stays_active: col=%0d want 4", col);
    end
    board[2][4] = 2'd2;
    pl = 1'b1;
    tick(7);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({row, col, done, rej} !== {3'd2, 3'd3, 2'b00}) begin
      errors++;
      $display("FAIL reset_async: r%0d c%0d d%b j%b want r2 c3 d0 j0",
               row, col, done, rej);
    end
    tick(3);
    pl = 1'b0;
    rst_n = 1'b1;
    tick(20);
    checks++;
    if (n_done !== nd || n_rej !== nr + 1) begin
      errors++;
      $display("FAIL reset_drops_strobe: done=%0d rej=%0d want 0 1",
               n_done - nd, n_rej - nr);
    end
    checks++;
    if ({row, col} !== {3'd2, 3'd3}) begin
      errors++;
      $display("FAIL reset_cursor: r%0d c%0d want r2 c3", row, col);
    end
  endtask

  initial begin
    test_reset();
    test_right_steps();
    test_wrap();
    test_glitch_repeat();
    test_place();
    test_reject_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cursor_input.md
# cursor_input

Player-side front end for the Othello board. Turns raw push-button levels into a debounced 8x8 board cursor and a one-cycle placement strobe for the game controller. It sits directly upstream of the controller: its `o_row`/`o_col`/`o_player_done` drive the controller's player-move inputs. It reads the controller's current board only to reject placements on occupied squares.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles needed before a key's debounced level changes (>=1).
- `REPEAT_DELAY`, default 25000000: cycles a direction key must be held before auto-repeat starts (>=1).
- `REPEAT_RATE`, default 10000000: cycles between auto-repeat steps (>=1).

Ports (clock and reset first):
- `i_clk` in 1: single clock.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_enable` in 1: high while the controller awaits a player move.
- `i_key_up`, `i_key_down`, `i_key_left`, `i_key_right` in 1 each: raw asynchronous key levels, active high.
- `i_key_place` in 1: raw asynchronous place key, active high.
- `i_board` in 2 per square, [0:7][0:7]: current board; value 2 means empty.
- `o_row` out 3: cursor row, registered.
- `o_col` out 3: cursor column, registered.
- `o_player_done` out 1: one-cycle strobe marking a legal-square placement.
- `o_reject` out 1: one-cycle strobe marking a placement attempt on an occupied square.

## Operation
- Each key passes through a 2-flop synchronizer, then its own debounce counter.
  - The counter clears whenever the synchronized level equals the debounced level.
  - Otherwise the counter increments.
  - When the counter reaches `DEBOUNCE_CYCLES`, the debounced level takes the synchronized value and the counter clears.
- Press event: a rising edge of a debounced level.
- Auto-repeat uses one shared counter and the highest-priority held direction key (up > down > left > right).
  - The counter clears on any direction press event or when no direction key is held.
  - The first repeat step fires after `REPEAT_DELAY` held cycles; later steps fire every `REPEAT_RATE` cycles.
  - A step acts as a press event of that key only.
- Cursor movement, applied only in ACTIVE state:
  - Up: row−1. Down: row+1. Left: col−1. Right: col+1.
  - All moves are modulo 8, so row 0 plus up gives row 7 and col 7 plus right gives col 0.
  - Up and down press events in the same cycle cancel; the row is unchanged. Left/right behave the same way.
  - A vertical event and a horizontal event in the same cycle both apply.
- State machine:
  - IDLE → ACTIVE when `i_enable`=1 and debounced place=0.
  - ACTIVE, `i_enable` falls with no place event → IDLE.
  - ACTIVE, place event and `i_board[o_row][o_col]`==2 → pulse `o_player_done`, then LOCK.
  - ACTIVE, place event on an occupied square → pulse `o_reject`, stay in ACTIVE.
  - LOCK → IDLE once `i_enable`=0 has been sampled.
- In IDLE and LOCK, direction and place events are discarded and the cursor is frozen.
- The IDLE → ACTIVE gate blocks a held place key from issuing a second placement.
- A place event and a direction event in the same ACTIVE cycle: the placement tests the pre-move cursor, and the cursor does not move.
- If the controller rejects the move (no flips) it raises `i_enable` again; the block returns to ACTIVE with the cursor unchanged.

## Timing
- Reset values:
  - `o_row`=2, `o_col`=3.
  - `o_player_done`=0, `o_reject`=0.
  - State=IDLE.
  - All debounced levels 0; all counters 0; synchronizers 0.
- Latency from a raw key edge (first sampling edge = cycle 0):
  - Synchronized output changes at cycle 2.
  - Debounced level changes at cycle 2+`DEBOUNCE_CYCLES`.
  - Cursor or strobe outputs update on the next edge, cycle 3+`DEBOUNCE_CYCLES`.
- `o_player_done` is high for exactly one cycle.
- `o_row`/`o_col` hold the placed square from the `o_player_done` cycle until the block next re-enters ACTIVE.
- `i_board` is sampled combinationally in the cycle of the place event.
- Reset asserted mid-operation (any state, any counter value) returns every register to its reset value immediately; any pending strobe is dropped.
- A key release shorter than `DEBOUNCE_CYCLES` never produces an event.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=20, `REPEAT_RATE`=8.
- Reset released, no keys pressed → `o_row`=2, `o_col`=3, both strobes 0 for 100 cycles.
- `i_enable`=1, press right 3 times (each held 10 cycles, 10 cycles apart) → `o_col` steps to 4, 5, 6; each change lands exactly 7 cycles after the raw edge.
- From row 0, press up once → `o_row`=7. From col 7, press right once → `o_col`=0. Press up and down together → row unchanged.
- Glitch of 3 cycles on the left key → no cursor change. Hold down for 60 cycles → row advances at cycles 7, 27, 35, 43, 51, 59 after the raw edge.
- Cursor at (2,3), board[2][3]=2, press place → `o_player_done` high for 1 cycle with `o_row`=2, `o_col`=3. Hold place while `i_enable` toggles 1→0→1 → no second strobe until place is released and debounced.
- board[2][3]=1, press place → `o_reject` pulse, no `o_player_done`, state stays ACTIVE. Assert `i_rst_n`=0 mid-debounce → outputs return to (2,3) immediately, with no strobe.
